// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: control FSM for the multicycle MIPS datapath.
// Sequences the shared ALU, the unified memory and the register file over
// 3-5 cycles per instruction. It stalls in FETCH, MEM_READ and MEM_WRITE
// until mem_ready is high.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode            IR[31:26], held stable by the IR from DECODE onward
//   zero              ALU zero flag (PC gating lives in the datapath)
//   mem_ready         memory completed the current access this cycle
//   pc_write .. pc_source   datapath enables and mux selects
//   instr_done        one-cycle pulse when an instruction retires
//   illegal_op        one-cycle pulse in DECODE on an unsupported opcode
//   state_o           current state, for debug
//   cycle_cnt, instr_cnt    performance counters
//
// Optional feature: define MIPS_CTRL_PERF_CNT_EN to build the cycle and
// retired-instruction counters. Without it both ports read 0 and no
// counter flops exist.
module mips_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ext_op,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;

  // The branch decision is made in the datapath; zero is only passed through there.
  logic unused_zero;
  assign unused_zero = zero;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and control outputs
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_op        = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // rst_n gate keeps the IR and PC untouched while reset is held.
        if (mem_ready && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_RTYPE:                state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        branch_ne     = (opcode == OP_BNE);
        alu_op        = (opcode == OP_BNE) ? 3'b011 : 3'b001;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        // Opcode is still held by the IR, so write-back re-derives the same ALU setup.
        if (state_q == S_I_EXEC) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_I_WB;
        end else begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        case (opcode)
          OP_ORI: begin
            ext_op = 2'b01;
            alu_op = 3'b100;
          end
          OP_LUI:  ext_op = 2'b10;
          default: ext_op = 2'b00;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state_o = STATE_W'(state_q);

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  // Free-running cycle and retirement counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. It applies a directed vector
// table, then random instruction streams against a path-based reference
// model, then resets the design in the middle of a store.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, ext_op, pc_source;
  logic [2:0]  alu_op;
  logic        instr_done, illegal_op;
  logic [3:0]  state_o;
  logic [31:0] cycle_cnt, instr_cnt;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_o(state_o), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, ext_op;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;
  } ctrl_t;

  // Directed vector: inputs, then the expected subset of outputs.
  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic [2:0] aluop;
    logic [1:0] srcb;
    logic [1:0] ext;
    logic       rw, rdst, mw, mrd, iord, done, ill, pcwc, bne;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cycles = 0;
  int   exp_instr = 0;

  function automatic ctrl_t actual();
    ctrl_t a;
    a = '{pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ext_op, alu_op,
          pc_source, instr_done, illegal_op, state_o};
    return a;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b};
  endfunction

  // Reference: the instruction's walk through numbered steps.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'h23:                      return 5;
      6'h2b, 6'h00, 6'h08, 6'h0d, 6'h0f: return 4;
      6'h04, 6'h05, 6'h02:        return 3;
      default:                    return 2;
    endcase
  endfunction

  function automatic int path_at(input logic [5:0] op, input int i);
    int p[5];
    case (op)
      6'h23:               p = '{0, 1, 2, 3, 4};
      6'h2b:               p = '{0, 1, 2, 5, 0};
      6'h00:               p = '{0, 1, 6, 7, 0};
      6'h04, 6'h05:        p = '{0, 1, 8, 0, 0};
      6'h02:               p = '{0, 1, 9, 0, 0};
      6'h08, 6'h0d, 6'h0f: p = '{0, 1, 10, 11, 0};
      default:             p = '{0, 1, 0, 0, 0};
    endcase
    return p[i];
  endfunction

  // Reference: control values required in step st, each field stated on its own.
  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input logic mr);
    ctrl_t e;
    bit imm;
    e = '0;
    imm = (st == 10 || st == 11);
    e.state         = 4'(st);
    e.mem_read      = (st == 0 || st == 3);
    e.ir_write      = (st == 0) && mr;
    e.pc_write      = ((st == 0) && mr) || st == 9;
    e.iord          = (st == 3 || st == 5);
    e.mem_write     = (st == 5);
    e.reg_write     = (st == 4 || st == 7 || st == 11);
    e.mem_to_reg    = (st == 4);
    e.reg_dst       = (st == 7);
    e.alu_src_a     = (st == 2 || st == 6 || st == 8 || st == 10);
    e.alu_src_b     = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 :
                      (st == 2 || st == 10) ? 2'b10 : 2'b00;
    e.ext_op        = (imm && op == 6'h0d) ? 2'b01 : (imm && op == 6'h0f) ? 2'b10 : 2'b00;
    e.alu_op        = (st == 6) ? 3'b010 :
                      (st == 8) ? ((op == 6'h05) ? 3'b011 : 3'b001) :
                      (imm && op == 6'h0d) ? 3'b100 : 3'b000;
    e.pc_write_cond = (st == 8);
    e.branch_ne     = (st == 8) && (op == 6'h05);
    e.pc_source     = (st == 8) ? 2'b01 : (st == 9) ? 2'b10 : 2'b00;
    e.instr_done    = (st == 4 || st == 7 || st == 8 || st == 9 || st == 11) ||
                      ((st == 5) && mr);
    e.illegal_op    = (st == 1) && !legal(op);
    return e;
  endfunction

  task automatic check_ctrl(input string name, input ctrl_t e);
    ctrl_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h (state %0d)", name, a, e, e.state);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [2:0] aluop, input logic [1:0] srcb, input logic [1:0] ext,
                     input logic rw, input logic rdst, input logic mw, input logic mrd,
                     input logic io, input logic done, input logic ill, input logic pcwc,
                     input logic bne);
    vec_t v;
    v = '{op, mr, st, aluop, srcb, ext, rw, rdst, mw, mrd, io, done, ill, pcwc, bne};
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic [27:0] got, req;
    opcode    = v.op;
    mem_ready = v.mr;
    zero      = 1'($urandom);
    #1;
    got = {state_o, alu_op, alu_src_b, ext_op, reg_write, reg_dst, mem_write, mem_read,
           iord, instr_done, illegal_op, pc_write_cond, branch_ne, 5'd0};
    req = {v.st, v.aluop, v.srcb, v.ext, v.rw, v.rdst, v.mw, v.mrd,
           v.iord, v.done, v.ill, v.pcwc, v.bne, 5'd0};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL vec%0d op=%h: got %h required %h", idx, v.op, got, req);
    end
    if (v.done) exp_instr++;
    @(posedge clk);
    #1;
    exp_cycles++;
  endtask

  // Runs one instruction through the model; memory-wait steps stall at random.
  task automatic run_instr(input logic [5:0] op);
    int   len, st, stalls;
    logic mr;
    bit   adv;
    len = path_len(op);
    for (int i = 0; i < len; i++) begin
      st = path_at(op, i);
      stalls = 0;
      do begin
        mr = (stalls >= 8) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        opcode    = op;
        mem_ready = mr;
        zero      = 1'($urandom);
        #1;
        check_ctrl($sformatf("rand op=%h", op), exp_ctrl(st, op, mr));
        if (exp_ctrl(st, op, mr).instr_done) exp_instr++;
        adv = !(st == 0 || st == 3 || st == 5) || mr;
        stalls++;
        @(posedge clk);
        #1;
        exp_cycles++;
      end while (!adv);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[9];
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 8)];
  endfunction

  initial begin
    //   op     mr  st  aop srcb ext rw rd mw mrd io dn il pc bn
    // R-type
    add(6'h00, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h00, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h00, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h00, 1, 7, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    // lw with three stall cycles in MEM_READ
    add(6'h23, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h23, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h23, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h23, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6'h23, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6'h23, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6'h23, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(6'h23, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    // bne, then beq
    add(6'h05, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h05, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h05, 1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    add(6'h04, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h04, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h04, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // ori, lui
    add(6'h0d, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h0d, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h0d, 1, 10, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h0d, 1, 11, 4, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(6'h0f, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h0f, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h0f, 1, 10, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h0f, 1, 11, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    // illegal opcode
    add(6'h3f, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h3f, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // sw with a fetch stall and a write stall
    add(6'h2b, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h2b, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(6'h2b, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h2b, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6'h2b, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(6'h2b, 1, 5, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    add(6'h00, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset state, with mem_ready high so the FETCH load enables must stay off.
    rst_n = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check_ctrl("reset", exp_ctrl(0, 6'h00, 1'b0));
    check_val("reset cycle_cnt", cycle_cnt, 32'd0);
    check_val("reset instr_cnt", instr_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cycles = 0;
    exp_instr  = 0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);
    // Last vector was a FETCH of an R-type; finish it so the model starts aligned.
    opcode = 6'h00; mem_ready = 1'b1;
    for (int s = 1; s < 4; s++) begin
      #1;
      check_ctrl("rtype tail", exp_ctrl(path_at(6'h00, s), 6'h00, 1'b1));
      if (exp_ctrl(path_at(6'h00, s), 6'h00, 1'b1).instr_done) exp_instr++;
      @(posedge clk);
      #1;
      exp_cycles++;
    end

    for (int n = 0; n < 300; n++) run_instr(pick_op());

`ifdef MIPS_CTRL_PERF_CNT_EN
    check_val("cycle_cnt", cycle_cnt, 32'(exp_cycles));
    check_val("instr_cnt", instr_cnt, 32'(exp_instr));
`else
    check_val("cycle_cnt tied", cycle_cnt, 32'd0);
    check_val("instr_cnt tied", instr_cnt, 32'd0);
`endif

    // Reset in the middle of a stalled store.
    opcode = 6'h2b;
    mem_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    check_ctrl("sw stalled", exp_ctrl(5, 6'h2b, 1'b0));
    rst_n = 1'b0;
    #1;
    check_ctrl("reset mid-sw", exp_ctrl(0, 6'h2b, 1'b0));
    check_val("mid-sw cycle_cnt", cycle_cnt, 32'd0);
    check_val("mid-sw instr_cnt", instr_cnt, 32'd0);
    @(posedge clk);
    #1;
    check_ctrl("reset held", exp_ctrl(0, 6'h2b, 1'b0));
    rst_n = 1'b1;
    exp_cycles = 0;
    exp_instr  = 0;
    for (int n = 0; n < 20; n++) run_instr(pick_op());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the multicycle MIPS variant.
- Sequences the shared ALU, the unified memory and the register file over 3–5 cycles per instruction.
- Emits the 3-bit ALUOp consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state_o debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- branch_ne  out  1  1 = load PC when zero==0 (bne); 0 = load when zero==1 (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = extended immediate, 11 = sign-extended immediate <<2.
- ext_op  out  2  immediate extension: 00 = sign, 01 = zero, 10 = upper (imm<<16).
- alu_op  out  3  ALUOp: 000 = add, 001 = beq-sub, 011 = bne-sub, 100 = or, 010 = R-type (funct decides).
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  STATE_W  current state (debug).
- cycle_cnt  out  32  cycle counter (optional feature).
- instr_cnt  out  32  retired-instruction counter (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State forced to FETCH(0).
  - All outputs 0, except those FETCH drives combinationally (mem_read=1, alu_src_b=01).
- Default: every output is 0 unless listed for the current state.
- FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1 (Mealy); then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 100011 / 101011 (lw/sw) -> MEM_ADDR(2).
  - 000000 (R-type) -> R_EXEC(6).
  - 000100 / 000101 (beq/bne) -> BRANCH(8).
  - 000010 (j) -> JUMP(9).
  - 001000 / 001101 / 001111 (addi/ori/lui) -> I_EXEC(10).
  - Any other opcode -> illegal_op=1, then FETCH; no architectural write.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, ext_op=00, alu_op=000 -> MEM_READ(3) for lw, MEM_WRITE(5) for sw.
- MEM_READ(3): mem_read=1, iord=1; hold until mem_ready=1 -> MEM_WB(4).
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WRITE(5): mem_write=1, iord=1; hold until mem_ready=1, then instr_done=1 -> FETCH.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB(7).
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
  - beq: alu_op=001, branch_ne=0.
  - bne: alu_op=011, branch_ne=1.
  - The PC-enable gating (pc_write | pc_write_cond & (zero ^ branch_ne)) lives in the datapath, not in this block.
- JUMP(9): pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- I_EXEC(10): alu_src_a=1, alu_src_b=10 -> I_WB(11).
  - addi: ext_op=00, alu_op=000.
  - ori: ext_op=01, alu_op=100.
  - lui: ext_op=10, alu_op=000 (datapath zeroes the A operand).
- I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0; holds I_EXEC's ext_op/alu_op; instr_done=1 -> FETCH.
- Opcode is not latched internally: the IR holds it stable from DECODE until the next FETCH ir_write.
- Unused encodings 12–15 -> FETCH on the next edge, all outputs 0.
- Reset mid-instruction: aborts immediately; no partial write may be asserted after rst_n falls.
- Write-enable rules:
  - mem_write and reg_write are never both 1.
  - ir_write is never 1 outside FETCH.

Optional Feature:
- Macro: MIPS_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clock while out of reset.
  - instr_cnt increments on each instr_done.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: both ports tied to 32'd0; no counter flops.

Test Plan:
- Reset release, opcode=000000, mem_ready=1 constantly -> FETCH, DECODE, R_EXEC with alu_op=010, R_WB with reg_write=1, reg_dst=1; instr_done pulses once in cycle 4.
- lw (100011), mem_ready low for 3 cycles in MEM_READ -> state_o holds 3, mem_read=1, iord=1 throughout; MEM_WB after mem_ready; 5 active cycles plus 3 stall cycles.
- bne (000101) -> BRANCH drives alu_op=011, branch_ne=1, pc_write_cond=1, pc_source=01; repeat with beq -> alu_op=001, branch_ne=0.
- ori (001101) -> I_EXEC/I_WB with ext_op=01, alu_op=100; lui (001111) -> ext_op=10, alu_op=000; both end with reg_write=1, reg_dst=0.
- Opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, reg_write/mem_write never asserted.
- Assert rst_n=0 while in MEM_WRITE with mem_ready=0 -> state_o=0 asynchronously, mem_write=0 before the next clock; with MIPS_CTRL_PERF_CNT_EN, both counters read 0 after reset.
